// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA timing receiver: pixel coordinates, line/frame measurement, lock FSM
module vga_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_en,
  input  logic [11:0] i_rgb,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_pix_valid,
  output logic [11:0] o_pix_rgb,
  output logic        o_frame_start,
  output logic [10:0] o_h_meas,
  output logic [10:0] o_v_meas,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [10:0] LP_H_TOTAL  = 11'(H_TOTAL);
  localparam logic [10:0] LP_V_TOTAL  = 11'(V_TOTAL);
  localparam logic [9:0]  LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [3:0]  LP_LOCK     = 4'(LOCK_FRAMES);
  localparam logic [10:0] LP_CNT_MAX  = 11'h7FF;
  localparam logic [9:0]  LP_POS_MAX  = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // input stage and sync history
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_en;
  logic [11:0] r_s1_rgb;
  logic        r_p_hs;
  logic        r_p_vs;

  // measurement counters
  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic [10:0] r_h_meas;
  logic [10:0] r_v_meas;
  logic        r_frame_start;

  // active-pixel tracking
  logic [9:0]  r_xcnt;
  logic [9:0]  r_lines_act;
  logic        r_line_has_en;

  // pixel output registers
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_pix_valid;
  logic [11:0] r_pix_rgb;

  // line-check bookkeeping and lock FSM
  logic        r_seen_hs;
  logic        r_any_bad;
  state_t      r_state;
  logic [3:0]  r_good_cnt;
  logic        r_locked;
  logic        r_err;

  logic        w_hs_fall;
  logic        w_vs_fall;
  logic [10:0] w_hcnt_p1;
  logic [9:0]  w_x_cur;
  logic [9:0]  w_x_next;
  logic [9:0]  w_lines_eff;
  logic [9:0]  w_y_cur;
  logic        w_bad_line;
  logic        w_bad_frame;

  // edge detection, saturating increments, and the line/frame verdicts
  always_comb begin
    w_hs_fall   = r_p_hs & ~r_s1_hs;
    w_vs_fall   = r_p_vs & ~r_s1_vs;
    w_hcnt_p1   = (r_hcnt == LP_CNT_MAX) ? LP_CNT_MAX : r_hcnt + 11'd1;
    // x of the pixel in S1: a hsync edge restarts the column count
    w_x_cur     = w_hs_fall ? 10'd0 : r_xcnt;
    w_x_next    = (r_s1_en && (w_x_cur != LP_POS_MAX)) ? w_x_cur + 10'd1 : w_x_cur;
    // the line terminated by this hsync edge counts if it carried any en
    w_lines_eff = (w_hs_fall && r_line_has_en && (r_lines_act != LP_POS_MAX))
                  ? r_lines_act + 10'd1 : r_lines_act;
    w_y_cur     = w_vs_fall ? 10'd0 : w_lines_eff;
    // the first hsync edge after reset ends a partial line and is not judged
    w_bad_line  = w_hs_fall && r_seen_hs &&
                  ((w_hcnt_p1 != LP_H_TOTAL) ||
                   ((r_xcnt != 10'd0) && (r_xcnt != LP_H_ACTIVE)));
    w_bad_frame = (r_vcnt != LP_V_TOTAL) || (w_lines_eff != LP_V_ACTIVE) ||
                  r_any_bad || w_bad_line;
  end

  // register the raw inputs once and keep the previous sync levels
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
      r_s1_en  <= 1'b0;
      r_s1_rgb <= 12'd0;
      r_p_hs   <= 1'b1;
      r_p_vs   <= 1'b1;
    end else begin
      r_s1_hs  <= i_hsync;
      r_s1_vs  <= i_vsync;
      r_s1_en  <= i_en;
      r_s1_rgb <= i_rgb;
      r_p_hs   <= r_s1_hs;
      r_p_vs   <= r_s1_vs;
    end
  end

  // clocks per line: saturating counter captured at each hsync edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt   <= 11'd0;
      r_h_meas <= 11'd0;
    end else if (w_hs_fall) begin
      r_h_meas <= w_hcnt_p1;
      r_hcnt   <= 11'd0;
    end else if (r_hcnt != LP_CNT_MAX) begin
      r_hcnt   <= r_hcnt + 11'd1;
    end
  end

  // lines per frame: vsync edge wins over a coincident hsync edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vcnt        <= 11'd0;
      r_v_meas      <= 11'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_vs_fall;
      if (w_vs_fall) begin
        r_v_meas <= r_vcnt;
        r_vcnt   <= 11'd0;
      end else if (w_hs_fall && (r_vcnt != LP_CNT_MAX)) begin
        r_vcnt   <= r_vcnt + 11'd1;
      end
    end
  end

  // column and active-line tracking for coordinate recovery
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xcnt        <= 10'd0;
      r_lines_act   <= 10'd0;
      r_line_has_en <= 1'b0;
    end else begin
      r_xcnt <= w_x_next;
      if (w_hs_fall || w_vs_fall) begin
        r_lines_act <= w_y_cur;
      end
      if (w_hs_fall) begin
        r_line_has_en <= r_s1_en;
      end else begin
        r_line_has_en <= r_line_has_en | r_s1_en;
      end
    end
  end

  // pixel output stage: second register after the input stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_valid <= 1'b0;
      r_pix_rgb   <= 12'd0;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
    end else begin
      r_pix_valid <= r_s1_en;
      r_pix_rgb   <= r_s1_rgb;
      r_x         <= w_x_cur;
      r_y         <= w_y_cur;
    end
  end

  // remember whether a full line was seen and whether any line of this frame was bad
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seen_hs <= 1'b0;
      r_any_bad <= 1'b0;
    end else begin
      if (w_hs_fall) begin
        r_seen_hs <= 1'b1;
      end
      if (w_vs_fall) begin
        r_any_bad <= 1'b0;
      end else if (w_bad_line) begin
        r_any_bad <= 1'b1;
      end
    end
  end

  // lock FSM: search for a frame boundary, count good frames, drop lock on any violation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= 4'd0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_vs_fall) begin
            r_state    <= ST_CHECK;
            r_good_cnt <= 4'd0;
          end
        end
        ST_CHECK: begin
          if (w_vs_fall) begin
            if (w_bad_frame) begin
              r_good_cnt <= 4'd0;
            end else begin
              r_good_cnt <= r_good_cnt + 4'd1;
              if ((r_good_cnt + 4'd1) == LP_LOCK) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end
          end
        end
        ST_LOCKED: begin
          // a bad line and a bad frame in the same cycle still give a single pulse
          if (w_bad_line || (w_vs_fall && w_bad_frame)) begin
            r_err      <= 1'b1;
            r_locked   <= 1'b0;
            r_good_cnt <= 4'd0;
            r_state    <= ST_SEARCH;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_pix_valid   = r_pix_valid;
  assign o_pix_rgb     = r_pix_rgb;
  assign o_frame_start = r_frame_start;
  assign o_h_meas      = r_h_meas;
  assign o_v_meas      = r_v_meas;
  assign o_locked      = r_locked;
  assign o_err         = r_err;

endmodule
